// File: rtl/imem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_ctrl_pkg
// Shared definitions for the instruction-memory load controller:
//   - BYTES_PER_WORD    : program bytes per instruction word (4)
//   - HALT_WORD_DEFAULT : default instruction word that terminates a load
//   - imem_state_e      : controller state encoding
//   - cpu_active()      : true for states in which the CPU pipeline may advance
// Configuration macro: IMEM_STEP_MODE_EN adds the single-step state STEP.
// -----------------------------------------------------------------------------
package imem_ctrl_pkg;

    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        READY = 3'd3,
        RUN   = 3'd4,
`ifdef IMEM_STEP_MODE_EN
        STEP  = 3'd5,
`endif
        DONE  = 3'd6
    } imem_state_e;

    // The pipeline is released (no stall, no PC hold) only while running or stepping.
    function automatic logic cpu_active(input imem_state_e st);
        logic act;
        case (st)
            RUN:     act = 1'b1;
`ifdef IMEM_STEP_MODE_EN
            STEP:    act = 1'b1;
`endif
            default: act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/byte_to_word_assembler.sv
// -----------------------------------------------------------------------------
// byte_to_word_assembler
// Collects BYTES_PER_WORD bytes little-endian (first byte -> bits 7:0) into one
// 32-bit word. The completed word and its done pulse are presented
// combinationally in the cycle the last byte is accepted, so the caller can
// register the word on that same edge.
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_clear          : synchronous clear of any partial word
//   i_byte_valid     : a byte is accepted this cycle
//   i_byte           : the byte
//   o_word           : word including the byte accepted this cycle
//   o_word_done      : pulses with the last byte of a word
// -----------------------------------------------------------------------------
module byte_to_word_assembler
    import imem_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    localparam int unsigned     CNT_W     = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    logic [31:0]      shift_r;
    logic [CNT_W-1:0] cnt_r;

    // Shift register fills from the top so the first byte ends up lowest.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            shift_r <= 32'h0000_0000;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (i_byte_valid) begin
            shift_r <= {i_byte, shift_r[31:8]};
            cnt_r   <= (cnt_r == LAST_BYTE) ? {CNT_W{1'b0}} : cnt_r + 1'b1;
        end
    end

    assign o_word      = {i_byte, shift_r[31:8]};
    assign o_word_done = i_byte_valid && (cnt_r == LAST_BYTE);

endmodule

// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
// Loads a program byte stream into instruction memory (one word per WRITE
// cycle, address 4*k), then controls the CPU: run, single step, done.
// Parameters: ADDR_WIDTH (byte address width), HALT_WORD (load terminator).
// Ports:
//   i_clk, i_reset                      : clock, synchronous active-high reset
//   i_rx_data/i_rx_valid/o_rx_ready     : program byte stream (valid&ready)
//   i_load/i_run/i_step                 : command pulses (load > run > step)
//   i_cpu_halted                        : pipeline retired a halt
//   o_write_instruction_mem/_addr/_data : instruction-memory write port
//   o_stall/o_halt/o_cpu_reset          : pipeline control
//   o_loaded/o_overflow/o_done          : status
// Configuration macro: IMEM_STEP_MODE_EN enables single-step (STEP state);
// without it i_step is ignored.
// -----------------------------------------------------------------------------
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    input  logic        i_load,
    input  logic        i_run,
    input  logic        i_step,
    input  logic        i_cpu_halted,
    output logic        o_write_instruction_mem,
    output logic [31:0] o_instruction_mem_addr,
    output logic [31:0] o_instruction_mem_data,
    output logic        o_stall,
    output logic        o_halt,
    output logic        o_cpu_reset,
    output logic        o_loaded,
    output logic        o_overflow,
    output logic        o_done
);

    localparam int unsigned    K_W    = ADDR_WIDTH - 2;
    localparam int unsigned    PAD_W  = 32 - ADDR_WIDTH;
    localparam logic [K_W-1:0] K_LAST = {K_W{1'b1}};

    imem_state_e    state_r;
    imem_state_e    next_state_s;
    logic [K_W-1:0] k_r;
    logic           rx_ready_r;
    logic           wr_r;
    logic [31:0]    addr_r;
    logic [31:0]    data_r;
    logic           stall_r;
    logic           halt_r;
    logic           cpu_reset_r;
    logic           loaded_r;
    logic           overflow_r;
    logic           done_r;

    logic           accept_s;
    logic           start_load_s;
    logic           word_done_s;
    logic [31:0]    word_s;
    logic           halt_hit_s;
    logic           last_word_s;

`ifndef IMEM_STEP_MODE_EN
    logic unused_step_s;
    assign unused_step_s = i_step;
`endif

    assign accept_s     = i_rx_valid && rx_ready_r;
    assign start_load_s = i_load && ((state_r == IDLE) || (state_r == READY) || (state_r == DONE));
    // In WRITE, data_r/k_r describe the word being written.
    assign halt_hit_s   = (data_r == HALT_WORD);
    assign last_word_s  = (k_r == K_LAST);

    byte_to_word_assembler u_asm (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (start_load_s),
        .i_byte_valid (accept_s),
        .i_byte       (i_rx_data),
        .o_word       (word_s),
        .o_word_done  (word_done_s)
    );

    // Next-state decode; command priority is load > run > step.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_load) next_state_s = LOAD;
                else        next_state_s = IDLE;
            end
            LOAD: begin
                if (word_done_s) next_state_s = WRITE;
                else             next_state_s = LOAD;
            end
            WRITE: begin
                if (halt_hit_s || last_word_s) next_state_s = READY;
                else                           next_state_s = LOAD;
            end
`ifdef IMEM_STEP_MODE_EN
            READY: begin
                if (i_load)      next_state_s = LOAD;
                else if (i_run)  next_state_s = RUN;
                else if (i_step) next_state_s = STEP;
                else             next_state_s = READY;
            end
            STEP: begin
                if (i_cpu_halted) next_state_s = DONE;
                else              next_state_s = READY;
            end
`else
            READY: begin
                if (i_load)     next_state_s = LOAD;
                else if (i_run) next_state_s = RUN;
                else            next_state_s = READY;
            end
`endif
            RUN: begin
                if (i_cpu_halted) next_state_s = DONE;
                else              next_state_s = RUN;
            end
            DONE: begin
                if (i_load) next_state_s = LOAD;
                else        next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register and outputs registered from the next state so they line up with it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= IDLE;
            rx_ready_r  <= 1'b0;
            wr_r        <= 1'b0;
            stall_r     <= 1'b1;
            halt_r      <= 1'b1;
            cpu_reset_r <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            rx_ready_r  <= (next_state_s == LOAD);
            wr_r        <= (next_state_s == WRITE);
            stall_r     <= !cpu_active(next_state_s);
            halt_r      <= !cpu_active(next_state_s);
            // Pipeline stays in reset while memory changes, plus the first READY cycle.
            cpu_reset_r <= (next_state_s == IDLE) || (next_state_s == LOAD) ||
                           (next_state_s == WRITE) ||
                           ((state_r == WRITE) && (next_state_s == READY));
            done_r      <= (next_state_s == DONE);
        end
    end

    // Word index and load status; overflow is sticky until the next load command.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            k_r        <= {K_W{1'b0}};
            loaded_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else if (start_load_s) begin
            k_r        <= {K_W{1'b0}};
            loaded_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else if (state_r == WRITE) begin
            if (halt_hit_s) begin
                loaded_r <= 1'b1;
            end else if (last_word_s) begin
                loaded_r   <= 1'b1;
                overflow_r <= 1'b1;
            end else begin
                k_r <= k_r + 1'b1;
            end
        end
    end

    // Write address/data captured when a word completes; held otherwise.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            addr_r <= 32'h0000_0000;
            data_r <= 32'h0000_0000;
        end else if ((state_r == LOAD) && word_done_s) begin
            addr_r <= {{PAD_W{1'b0}}, k_r, 2'b00};
            data_r <= word_s;
        end
    end

    assign o_rx_ready              = rx_ready_r;
    assign o_write_instruction_mem = wr_r;
    assign o_instruction_mem_addr  = addr_r;
    assign o_instruction_mem_data  = data_r;
    assign o_stall                 = stall_r;
    assign o_halt                  = halt_r;
    assign o_cpu_reset             = cpu_reset_r;
    assign o_loaded                = loaded_r;
    assign o_overflow              = overflow_r;
    assign o_done                  = done_r;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_load_ctrl
// Randomized bench for imem_load_ctrl. A word-level reference model turns each
// program into its byte stream and the list of expected memory writes; a
// monitor compares every write strobe against that list.
// -----------------------------------------------------------------------------
module tb_imem_load_ctrl;

    localparam int unsigned MEM_BYTES = 4096;
    localparam logic [31:0] HALT      = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic        i_load, i_run, i_step, i_cpu_halted;
    logic        o_write_instruction_mem;
    logic [31:0] o_instruction_mem_addr, o_instruction_mem_data;
    logic        o_stall, o_halt, o_cpu_reset, o_loaded, o_overflow, o_done;

    int total = 0;
    int bad   = 0;
    int stall_low_cnt = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    imem_load_ctrl #(.ADDR_WIDTH(12), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .i_clk                   (i_clk),
        .i_reset                 (i_reset),
        .i_rx_data               (i_rx_data),
        .i_rx_valid              (i_rx_valid),
        .o_rx_ready              (o_rx_ready),
        .i_load                  (i_load),
        .i_run                   (i_run),
        .i_step                  (i_step),
        .i_cpu_halted            (i_cpu_halted),
        .o_write_instruction_mem (o_write_instruction_mem),
        .o_instruction_mem_addr  (o_instruction_mem_addr),
        .o_instruction_mem_data  (o_instruction_mem_data),
        .o_stall                 (o_stall),
        .o_halt                  (o_halt),
        .o_cpu_reset             (o_cpu_reset),
        .o_loaded                (o_loaded),
        .o_overflow              (o_overflow),
        .o_done                  (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Monitor: every write must match the model's next expected write.
    always @(negedge i_clk) begin
        if (o_stall === 1'b0) stall_low_cnt++;
        if (o_write_instruction_mem === 1'b1) begin
            if (exp_addr.size() == 0) begin
                chk("wr_unexpected", 64'd1, 64'd0);
            end else begin
                chk("wr_addr", o_instruction_mem_addr, exp_addr.pop_front());
                chk("wr_data", o_instruction_mem_data, exp_data.pop_front());
            end
            chk("wr_rx_ready", o_rx_ready, 1'b0);
            chk("wr_cpu_reset", o_cpu_reset, 1'b1);
            last_wr_addr = o_instruction_mem_addr;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, o_rx_ready, 1'b0);
        chk({tag, "_wr"}, o_write_instruction_mem, 1'b0);
        chk({tag, "_addr"}, o_instruction_mem_addr, 32'h0);
        chk({tag, "_data"}, o_instruction_mem_data, 32'h0);
        chk({tag, "_stall"}, o_stall, 1'b1);
        chk({tag, "_halt"}, o_halt, 1'b1);
        chk({tag, "_cpu_reset"}, o_cpu_reset, 1'b1);
        chk({tag, "_loaded"}, o_loaded, 1'b0);
        chk({tag, "_overflow"}, o_overflow, 1'b0);
        chk({tag, "_done"}, o_done, 1'b0);
    endtask

    // Drives bytes at negedges; a byte is consumed only if valid while ready was high.
    task automatic feed_bytes(input logic [7:0] bytes[$], input int mode);
        int   idx = 0;
        int   cyc = 0;
        int   budget = 4 * bytes.size() + 100;
        logic rdy, v;
        while (idx < bytes.size() && cyc < budget) begin
            rdy = o_rx_ready;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = ($urandom % 2) != 0;
            endcase
            i_rx_valid = v;
            i_rx_data  = v ? bytes[idx] : 8'($urandom);
            @(negedge i_clk);
            cyc++;
            if (v && rdy) idx++;
        end
        i_rx_valid = 1'b0;
        if (idx < bytes.size()) chk("feed_timeout", idx, bytes.size());
    endtask

    // Full load of a program; the model decides writes, end point and overflow.
    task automatic do_load(input logic [31:0] words[$], input int mode, input bit with_cmds);
        logic [7:0]  bytes[$];
        logic [31:0] w;
        bit          stop = 0;
        bit          exp_ovf = 0;
        int          cyc = 0;
        for (int i = 0; i < words.size() && !stop; i++) begin
            w = words[i];
            for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
            exp_addr.push_back(32'(4 * i));
            exp_data.push_back(w);
            if (w == HALT) stop = 1;
            else if (4 * i == MEM_BYTES - 4) begin stop = 1; exp_ovf = 1; end
        end
        i_load = 1'b1;
        if (with_cmds) begin i_run = 1'b1; i_step = 1'b1; end
        @(negedge i_clk);
        i_load = 1'b0; i_run = 1'b0; i_step = 1'b0;
        chk("load_start_loaded", o_loaded, 1'b0);
        chk("load_start_overflow", o_overflow, 1'b0);
        chk("load_start_done", o_done, 1'b0);
        chk("load_start_stall", o_stall, 1'b1);
        chk("load_start_cpu_reset", o_cpu_reset, 1'b1);
        feed_bytes(bytes, mode);
        while (o_loaded !== 1'b1 && cyc < 20) begin @(negedge i_clk); cyc++; end
        chk("load_ready_timeout", o_loaded, 1'b1);
        chk("ready_entry_cpu_reset", o_cpu_reset, 1'b1);
        chk("ready_overflow", o_overflow, exp_ovf);
        @(negedge i_clk);
        chk("ready_cpu_reset_off", o_cpu_reset, 1'b0);
        chk("ready_stall", o_stall, 1'b1);
        chk("ready_halt", o_halt, 1'b1);
        chk("writes_missing", exp_addr.size(), 0);
    endtask

    // From READY: run, raise cpu_halted after n cycles, expect n free-running cycles then DONE.
    task automatic run_for(input int n);
        stall_low_cnt = 0;
        i_run = 1'b1;
        @(negedge i_clk);
        i_run = 1'b0;
        chk("run_halt_low", o_halt, 1'b0);
        repeat (n - 1) @(negedge i_clk);
        i_cpu_halted = 1'b1;
        @(negedge i_clk);
        i_cpu_halted = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("run_stall_cycles", stall_low_cnt, n);
        chk("run_done", o_done, 1'b1);
        chk("run_done_halt", o_halt, 1'b1);
    endtask

    task automatic step_pulses(input int n);
        int exp_low;
`ifdef IMEM_STEP_MODE_EN
        exp_low = n;
`else
        exp_low = 0;
`endif
        stall_low_cnt = 0;
        for (int i = 0; i < n; i++) begin
            i_step = 1'b1;
            @(negedge i_clk);
            i_step = 1'b0;
            repeat (2) @(negedge i_clk);
        end
        chk("step_stall_cycles", stall_low_cnt, exp_low);
        chk("step_not_done", o_done, 1'b0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom();
        if (w == HALT) w = 32'h0000_0000;
        return w;
    endfunction

    initial begin
        logic [31:0] prog[$];
        logic [7:0]  part[$];
        int          nw;
        i_reset = 1'b1; i_rx_data = 8'h00; i_rx_valid = 1'b0;
        i_load = 1'b0; i_run = 1'b0; i_step = 1'b0; i_cpu_halted = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        i_reset = 1'b0;

        // IDLE ignores run and step.
        stall_low_cnt = 0;
        i_run = 1'b1; i_step = 1'b1;
        @(negedge i_clk);
        i_run = 1'b0; i_step = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("idle_stall_cycles", stall_low_cnt, 0);
        chk("idle_rx_ready", o_rx_ready, 1'b0);
        chk("idle_loaded", o_loaded, 1'b0);

        // Basic program: bytes 13,00,08,20 then FF x4.
        prog = '{32'h2008_0013, HALT};
        do_load(prog, 0, 0);
        // Same program with valid toggling, reloaded from READY.
        do_load(prog, 1, 0);
        run_for(10);

        // DONE ignores run and step.
        stall_low_cnt = 0;
        i_run = 1'b1; i_step = 1'b1;
        @(negedge i_clk);
        i_run = 1'b0; i_step = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("done_ignore_stall", stall_low_cnt, 0);
        chk("done_hold", o_done, 1'b1);

        // Random programs, random valid, some loads colliding with run/step.
        for (int it = 0; it < 6; it++) begin
            prog = {};
            nw = $urandom_range(1, 12);
            for (int i = 0; i < nw; i++) prog.push_back(rand_word());
            prog.push_back(HALT);
            do_load(prog, 2, (it % 2) == 1);
            if (it % 2 == 0) run_for($urandom_range(1, 15));
        end

        // Single-step from READY.
        step_pulses(3);
        // Step that retires a halt.
        i_step = 1'b1;
        @(negedge i_clk);
        i_step = 1'b0; i_cpu_halted = 1'b1;
        @(negedge i_clk);
        i_cpu_halted = 1'b0;
        @(negedge i_clk);
`ifdef IMEM_STEP_MODE_EN
        chk("step_halted_done", o_done, 1'b1);
`else
        chk("step_halted_done", o_done, 1'b0);
`endif

        // Reset after two bytes of a word, then a fresh load.
        i_load = 1'b1;
        @(negedge i_clk);
        i_load = 1'b0;
        part = '{8'hAA, 8'hBB};
        feed_bytes(part, 0);
        i_reset = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("midword_reset");
        i_reset = 1'b0;
        @(negedge i_clk);
        prog = '{32'h1122_3344, rand_word(), HALT};
        do_load(prog, 2, 0);

        // Memory limit without HALT_WORD.
        prog = {};
        for (int i = 0; i < MEM_BYTES / 4; i++) prog.push_back(rand_word());
        do_load(prog, 0, 0);
        chk("ovf_last_addr", last_wr_addr, 32'h0000_0FFC);
        chk("ovf_flag", o_overflow, 1'b1);
        // Sticky overflow clears on the next load.
        prog = '{rand_word(), HALT};
        do_load(prog, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, meaning instruction-memory byte-address width (4K bytes).
REQ-002 The block SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, meaning the instruction word that terminates a program load.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: i_clk (in, 1, rising-edge clock) and i_reset (in, 1, synchronous active-high reset).
REQ-004 The block SHALL have these data-input ports: i_rx_data (in, 8, program byte); i_rx_valid (in, 1, byte available); o_rx_ready (out, 1, byte accepted when valid&ready).
REQ-005 The block SHALL have these command and status inputs: i_load (in, 1, start-load command pulse); i_run (in, 1, run command pulse); i_step (in, 1, single-step command pulse); i_cpu_halted (in, 1, pipeline retired halt).
REQ-006 The block SHALL have these memory-write outputs: o_write_instruction_mem (out, 1, instruction-memory write strobe); o_instruction_mem_addr (out, 32, write byte address); o_instruction_mem_data (out, 32, write word).
REQ-007 The block SHALL have these control and status outputs: o_stall (out, 1, freeze fetch/pipeline); o_halt (out, 1, hold PC); o_cpu_reset (out, 1, pipeline reset); o_loaded (out, 1, program present); o_overflow (out, 1, sticky, load exceeded memory); o_done (out, 1, program finished).

Function
REQ-008 The block SHALL implement these states: IDLE, LOAD, WRITE, READY, RUN, STEP, DONE.
REQ-009 In IDLE, the block SHALL go to LOAD on i_load; it SHALL ignore i_run and i_step.
REQ-010 In LOAD, the block SHALL assert o_rx_ready and accept one byte per valid&ready cycle, little-endian (first byte -> bits 7:0); it SHALL go to WRITE after the 4th byte.
REQ-011 In WRITE, the block SHALL assert o_write_instruction_mem for exactly 1 cycle with address 4*k for word k (k from 0), with o_rx_ready low.
REQ-012 After WRITE, the block SHALL go to READY if the word equals HALT_WORD or the address equals 2^ADDR_WIDTH-4; otherwise it SHALL return to LOAD with k+1.
REQ-013 The block SHALL set o_overflow (sticky until the next i_load) when the memory limit ends the load without HALT_WORD; in that case it SHALL go to READY with o_loaded=1.
REQ-014 The block SHALL hold o_cpu_reset=1 throughout LOAD and WRITE, plus exactly one cycle on entry to READY.
REQ-015 The block SHALL set o_stall=1 and o_halt=1 in every state except RUN and STEP.
REQ-016 In READY, i_run SHALL go to RUN; i_step SHALL go to STEP; i_load SHALL go to LOAD and reset k to 0.
REQ-017 In RUN, the block SHALL set o_stall=0 and o_halt=0 until i_cpu_halted, then go to DONE the next cycle.
REQ-018 In STEP, the block SHALL deassert o_stall and o_halt for exactly 1 cycle, then return to READY; if i_cpu_halted, it SHALL go to DONE instead.
REQ-019 In DONE, the block SHALL set o_done=1; i_load SHALL go to LOAD, and i_run and i_step SHALL be ignored.
REQ-020 Simultaneous commands SHALL take priority i_load > i_run > i_step.
REQ-021 A byte arriving while o_rx_ready=0 SHALL NOT be consumed.
REQ-022 o_instruction_mem_addr and o_instruction_mem_data SHALL hold their last values outside WRITE.

Reset
REQ-023 On i_reset, the block SHALL go to IDLE with k=0 and these outputs: o_rx_ready=0, o_write_instruction_mem=0, o_instruction_mem_addr=0, o_instruction_mem_data=0, o_stall=1, o_halt=1, o_cpu_reset=1, o_loaded=0, o_overflow=0, o_done=0.
REQ-024 Reset SHALL dominate in all states, including mid-word and mid-step; a partial word SHALL be discarded.

Configuration
REQ-025 Macro IMEM_STEP_MODE_EN SHALL control single-step support: when defined, the STEP state and i_step behave as above; when undefined, the STEP state is absent, i_step is ignored, and i_step is still present as a port.

Structure
REQ-026 The state encoding, HALT_WORD default and the bytes-per-word constant (4) SHALL live in shared package imem_ctrl_pkg.
REQ-027 One sub-module, byte_to_word_assembler (shift register plus byte counter with done pulse), SHALL be natural; the FSM SHALL stay in imem_load_ctrl.

Verification
REQ-028 Reset then i_load, bytes 13,00,08,20, FF,FF,FF,FF -> writes (addr 0, 0x20080013) then (addr 4, 0xFFFFFFFF); READY; o_loaded=1; o_overflow=0.
REQ-029 i_rx_valid toggling every other cycle during the load -> identical writes with no lost or duplicated bytes.
REQ-030 Load of 1024 non-halt words (ADDR_WIDTH=12) -> last write at addr 0xFFC; READY; o_overflow=1.
REQ-031 READY, i_run, i_cpu_halted asserted 10 cycles later -> o_stall=0 for 10 cycles; DONE; o_done=1.
REQ-032 With IMEM_STEP_MODE_EN, three i_step pulses from READY -> exactly three single cycles with o_stall=0; without the macro -> o_stall stays 1.
REQ-033 i_reset after 2 bytes of a word, then a fresh load -> the first write is at addr 0 with only the new bytes.
